uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Parametrised UART receiver: oversampled start/data/stop framing, LSB first, configurable data width.
//  Received words go into an internal FIFO drained by a valid/ready stream interface.
//  Flags framing errors, overruns and (optionally) parity errors as single-cycle pulses.
//  Sits between the baud-tick generator and the host/register interface.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, legal 5..9
//  OSR         16  ticks per bit period; even, >=4
//  FIFO_DEPTH  4   receive FIFO entries; power of 2, >=2
//  PARITY_ODD  0   0 = even parity, 1 = odd parity; used only when UART_RX_PARITY_EN is defined
// PORTS
//  clk         in   1                   system clock
//  reset       in   1                   asynchronous, active-low reset
//  tick        in   1                   single-cycle oversample strobe, OSR per bit period
//  rx_in       in   1                   asynchronous serial line, idle high
//  m_data      out  DATA_BITS           FIFO head word
//  m_valid     out  1                   FIFO not empty
//  m_ready     in   1                   consumer pops the head when m_valid && m_ready
//  frame_err   out  1                   1-cycle pulse: stop bit sampled low
//  parity_err  out  1                   1-cycle pulse: parity mismatch; tied 0 without macro
//  overrun     out  1                   1-cycle pulse: completed word dropped, FIFO full
//  fifo_count  out  $clog2(FIFO_DEPTH+1)  words held
// BEHAVIOUR
//  Reset values:
//   - m_data=0, m_valid=0, all error pulses=0, fifo_count=0.
//   - FSM=IDLE; counters=0.
//   - Synchroniser flops=1 (line idle).
//  Input path:
//   - rx_in passes 2 sync flops to give rx_s.
//   - FSM and counters change only on cycles with tick=1; no edge detection of tick.
//  States:
//   - IDLE: rx_s==0 -> START, cnt=0.
//   - START: cnt++ each tick; at cnt==OSR/2-1:
//     rx_s==0 -> DATA, cnt=0, idx=0; rx_s==1 -> IDLE, no error flagged (glitch reject).
//   - DATA: at cnt==OSR-1, shift rx_s into shreg MSB (LSB-first assembly), idx++, cnt=0.
//     After bit DATA_BITS-1 -> PARITY (macro) or STOP. Otherwise cnt++.
//   - PARITY: at cnt==OSR-1, latch perr = (XOR(shreg)^rx_s) != PARITY_ODD; -> STOP, cnt=0.
//   - STOP: at cnt==OSR-1, go to IDLE (mid stop bit; back-to-back frames allowed).
//     rx_s==0: frame_err pulses.
//     perr: parity_err pulses.
//     Both may pulse together.
//     Push shreg only if no frame error and no parity error; failed words are discarded.
//  FIFO:
//   - m_data registered, first-word-fall-through.
//   - Push in stop-tick cycle N -> m_valid=1, m_data valid, count updated at N+1.
//   - Pop: m_valid && m_ready; the head advances the next cycle.
//   - Push when count==FIFO_DEPTH:
//     if a pop occurs the same cycle, the push is accepted and count is unchanged;
//     otherwise overrun pulses, the new word is dropped, and contents are untouched.
//   - Push and pop on a non-full, non-empty FIFO: count is unchanged.
//   - m_ready while empty: ignored.
//   - Pointers wrap modulo FIFO_DEPTH.
//  Reset asserted mid-frame or with data in the FIFO:
//   - Immediate return to reset values; partial frame and FIFO contents are lost.
//  Error pulses are high for exactly 1 clk cycle, in the cycle after the stop tick.
// CONFIGURATION
//  UART_RX_PARITY_EN defined:
//   - PARITY state is present; a frame is start + DATA_BITS + parity + stop.
//   - parity_err is active.
//  UART_RX_PARITY_EN undefined:
//   - No PARITY state; a frame is start + DATA_BITS + stop.
//   - parity_err is tied 0; PARITY_ODD is ignored.
// TESTING
//  1. OSR=16, 8N1, byte 0xA5, m_ready=1
//     -> one m_valid pulse with m_data=0xA5; no error pulses.
//  2. rx_in low for 4 ticks, then high
//     -> stays in IDLE; no m_valid; no error pulses.
//  3. Frame 0x3C with stop bit driven 0
//     -> frame_err pulses once; fifo_count stays 0; the next good frame 0x11 is received.
//  4. m_ready=0, send 0x01..0x05 (FIFO_DEPTH=4)
//     -> overrun pulses on the 5th word; pops return 0x01,0x02,0x03,0x04.
//  5. Macro on, even parity: 0x0F with parity bit 1
//     -> parity_err pulses, nothing pushed; 0x0F with parity bit 0 -> received.
//  6. Reset asserted mid-DATA with 2 words queued
//     -> all outputs at reset values; a following frame 0x5A is received cleanly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver (LSB first) feeding a first-word-fall-through receive FIFO.
// Define UART_RX_PARITY_EN to add a parity bit between the data bits and the stop bit.
module uart_rx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int OSR        = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int PARITY_ODD = 0
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              tick,
   input  logic                              rx_in,
   output logic [DATA_BITS-1:0]              m_data,
   output logic                              m_valid,
   input  logic                              m_ready,
   output logic                              frame_err,
   output logic                              parity_err,
   output logic                              overrun,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

   localparam int CW = $clog2(OSR);
   localparam int IW = $clog2(DATA_BITS + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int NW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] HALF_M1  = CW'(OSR / 2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(OSR - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
   localparam logic [NW-1:0] DEPTH_N  = NW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP
`ifdef UART_RX_PARITY_EN
      , S_PARITY
`endif
   } state_t;

   state_t                 state_q;
   logic [CW-1:0]          cnt_q;
   logic [IW-1:0]          idx_q;
   logic [DATA_BITS-1:0]   shreg_q;
   logic                   perr_q, frame_err_q, parity_err_q, overrun_q;
   logic                   sync1_q, sync2_q, rx_s;
   logic                   bit_tick, stop_tick, push;

   logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
   logic [DATA_BITS-1:0]   head_q, head_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [NW-1:0]          count_q, count_d;
   logic                   valid_q, pop, full, wr_en;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx_in;
         sync2_q <= sync1_q;
      end
   end
   assign rx_s = sync2_q;

   assign bit_tick  = tick && (state_q == S_DATA) && (cnt_q == FULL_M1);
   assign stop_tick = tick && (state_q == S_STOP) && (cnt_q == FULL_M1);
   assign push      = stop_tick && rx_s && !perr_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         idx_q        <= '0;
         perr_q       <= 1'b0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         if (tick) begin
            case (state_q)
               S_IDLE: begin
                  if (!rx_s) begin
                     state_q <= S_START;
                     cnt_q   <= '0;
                  end
               end
               S_START: begin
                  // A start bit that is gone by mid-bit is a glitch, not a frame.
                  if (cnt_q == HALF_M1) begin
                     cnt_q   <= '0;
                     idx_q   <= '0;
                     perr_q  <= 1'b0;
                     state_q <= rx_s ? S_IDLE : S_DATA;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               S_DATA: begin
                  if (cnt_q == FULL_M1) begin
                     cnt_q <= '0;
                     idx_q <= idx_q + IW'(1);
                     if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_q <= S_PARITY;
`else
                        state_q <= S_STOP;
`endif
                     end
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
`ifdef UART_RX_PARITY_EN
               S_PARITY: begin
                  if (cnt_q == FULL_M1) begin
                     perr_q  <= (((^shreg_q) ^ rx_s) != (PARITY_ODD != 0));
                     cnt_q   <= '0;
                     state_q <= S_STOP;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
`endif
               S_STOP: begin
                  // Leave at mid stop bit so a back-to-back start edge is not missed.
                  if (cnt_q == FULL_M1) begin
                     cnt_q        <= '0;
                     state_q      <= S_IDLE;
                     frame_err_q  <= !rx_s;
                     parity_err_q <= perr_q;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (bit_tick) shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
   end

   assign pop   = valid_q && m_ready;
   assign full  = (count_q == DEPTH_N);
   assign wr_en = push && (!full || pop);

   always_comb begin
      count_d  = count_q + NW'(wr_en) - NW'(pop);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(wr_en);
      head_d   = head_q;
      // The head register mirrors mem[rd_ptr], bypassing a word written into an emptying FIFO.
      if (wr_en && ((count_q == '0) || (pop && (count_q == NW'(1)))))
         head_d = shreg_q;
      else if (pop && (count_q > NW'(1)))
         head_d = mem_q[rd_ptr_q + PW'(1)];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q   <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         valid_q   <= 1'b0;
         head_q    <= '0;
         overrun_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         valid_q   <= (count_d != '0);
         head_q    <= head_d;
         overrun_q <= push && full && !pop;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= shreg_q;
   end

   assign m_data     = head_q;
   assign m_valid    = valid_q;
   assign fifo_count = count_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule
